// File: rtl/chip_intf_pkg.sv
// Shared definitions for the chip interface receive path: channel codes, network count, flit width.
// Combinational helpers only, no latency; carries no flow control of its own.
package chip_intf_pkg;

   localparam int NUM_NOC     = 3;
   localparam int FLIT_W      = 32;
   localparam int FLIT_CNT_W  = 32;
   localparam int DROP_CNT_W  = 16;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_NOC1 = 2'd1,
      CH_NOC2 = 2'd2,
      CH_NOC3 = 2'd3
   } chan_e;

   function automatic logic [NUM_NOC-1:0] chan_onehot(input chan_e ch);
      logic [NUM_NOC-1:0] oh;
      oh = '0;
      case (ch)
         CH_NOC1: oh = 3'b001;
         CH_NOC2: oh = 3'b010;
         CH_NOC3: oh = 3'b100;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/chip_intf_rx_fifo.sv
// Single-clock circular FIFO; head readable combinationally, write visible the cycle after push.
// A push while full only lands if a pop happens in the same cycle; otherwise the caller sees the drop.
module chip_intf_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic             io_clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Extra pointer MSB tells a wrapped (full) buffer apart from an empty one.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop_vld & ~empty;
   assign do_push  = push_vld & (~full | do_pop);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge io_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/chip_intf_rx_demux.sv
// Demuxes registered chip flits into three NoC buffers and returns one credit per pop; 2 cycles pin to valid.
// noc_ready holds the head stable; overflow only on chip credit violation. Stats under CHIP_INTF_RX_STATS_EN.
module chip_intf_rx_demux
   import chip_intf_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_W     = FLIT_W
) (
   input  logic                      io_clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         chip_intf_data,
   input  logic [1:0]                chip_intf_channel,
   output logic [NUM_NOC-1:0]        chip_intf_credit_back,
   output logic [NUM_NOC-1:0]        noc_valid,
   input  logic [NUM_NOC-1:0]        noc_ready,
   output logic [NUM_NOC*DATA_W-1:0] noc_data,
   output logic [NUM_NOC-1:0]        overflow_err
`ifdef CHIP_INTF_RX_STATS_EN
   ,
   output logic [NUM_NOC*FLIT_CNT_W-1:0] flit_cnt,
   output logic [NUM_NOC*DROP_CNT_W-1:0] drop_cnt
`endif
);

   logic [DATA_W-1:0]  in_dat;
   chan_e              in_ch;
   logic [NUM_NOC-1:0] push_vld;
   logic [NUM_NOC-1:0] pop_vld;
   logic [NUM_NOC-1:0] full;
   logic [NUM_NOC-1:0] empty;
   logic [NUM_NOC-1:0] drop;

   // Pins are captured unconditionally; the channel code alone qualifies the flit.
   always_ff @(posedge io_clk or posedge rst) begin
      if (rst) begin
         in_dat <= '0;
         in_ch  <= CH_IDLE;
      end else begin
         in_dat <= chip_intf_data;
         in_ch  <= chan_e'(chip_intf_channel);
      end
   end

   assign push_vld  = chan_onehot(in_ch);
   assign noc_valid = ~empty;
   assign pop_vld   = noc_valid & noc_ready;
   assign drop      = push_vld & full & ~pop_vld;

   for (genvar k = 0; k < NUM_NOC; k++) begin : g_noc
      chip_intf_rx_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (DATA_W)
      ) u_fifo (
         .io_clk   (io_clk),
         .rst      (rst),
         .push_vld (push_vld[k]),
         .push_dat (in_dat),
         .pop_vld  (pop_vld[k]),
         .head_dat (noc_data[k*DATA_W +: DATA_W]),
         .full     (full[k]),
         .empty    (empty[k])
      );
   end

   always_ff @(posedge io_clk or posedge rst) begin
      if (rst) begin
         chip_intf_credit_back <= '0;
         overflow_err          <= '0;
      end else begin
         chip_intf_credit_back <= pop_vld;
         overflow_err          <= overflow_err | drop;
      end
   end

`ifdef CHIP_INTF_RX_STATS_EN
   always_ff @(posedge io_clk or posedge rst) begin
      if (rst) begin
         flit_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_NOC; k++) begin
            if (push_vld[k] && !drop[k])
               flit_cnt[k*FLIT_CNT_W +: FLIT_CNT_W] <= flit_cnt[k*FLIT_CNT_W +: FLIT_CNT_W] + 1'b1;
            if (drop[k] && (drop_cnt[k*DROP_CNT_W +: DROP_CNT_W] != '1))
               drop_cnt[k*DROP_CNT_W +: DROP_CNT_W] <= drop_cnt[k*DROP_CNT_W +: DROP_CNT_W] + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_chip_intf_rx_demux.sv
// Randomized + directed bench for chip_intf_rx_demux with a queue-based reference model and scoreboard.
module tb_chip_intf_rx_demux;
   import chip_intf_pkg::*;

   localparam int DEPTH = 8;
   localparam int W     = 32;

   logic          io_clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  chip_intf_data = '0;
   logic [1:0]    chip_intf_channel = 2'd0;
   logic [2:0]    chip_intf_credit_back;
   logic [2:0]    noc_valid;
   logic [2:0]    noc_ready = 3'b000;
   logic [3*W-1:0] noc_data;
   logic [2:0]    overflow_err;
`ifdef CHIP_INTF_RX_STATS_EN
   logic [95:0]   flit_cnt;
   logic [47:0]   drop_cnt;
`endif

   chip_intf_rx_demux #(.FIFO_DEPTH(DEPTH), .DATA_W(W)) dut (
      .io_clk                (io_clk),
      .rst                   (rst),
      .chip_intf_data        (chip_intf_data),
      .chip_intf_channel     (chip_intf_channel),
      .chip_intf_credit_back (chip_intf_credit_back),
      .noc_valid             (noc_valid),
      .noc_ready             (noc_ready),
      .noc_data              (noc_data),
      .overflow_err          (overflow_err)
`ifdef CHIP_INTF_RX_STATS_EN
      ,
      .flit_cnt              (flit_cnt),
      .drop_cnt              (drop_cnt)
`endif
   );

   always #5 io_clk = ~io_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: buffer contents, the flit waiting in the pin register, and expected flags.
   logic [W-1:0] mq [3][$];
   logic [W-1:0] sb [3][$];
   logic [1:0]   m_ch = 2'd0;
   logic [W-1:0] m_dat = '0;
   logic [2:0]   m_credit = 3'b000;
   logic [2:0]   m_ovf = 3'b000;
   int unsigned  m_flits [3];
   int unsigned  m_drops [3];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge io_clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            sb[k].delete();
            m_flits[k] = 0;
            m_drops[k] = 0;
         end
         m_ch = 2'd0;
         m_dat = '0;
         m_credit = 3'b000;
         m_ovf = 3'b000;
      end else begin
         logic [2:0] pv;
         int c;
         for (int k = 0; k < 3; k++) begin
            pv[k] = (mq[k].size() != 0) && noc_ready[k];
            if (pv[k]) void'(mq[k].pop_front());
         end
         if (m_ch != 2'd0) begin
            c = int'(m_ch) - 1;
            if (mq[c].size() >= DEPTH) begin
               m_ovf[c] = 1'b1;
               if (m_drops[c] < 65535) m_drops[c]++;
            end else begin
               mq[c].push_back(m_dat);
               sb[c].push_back(m_dat);
               m_flits[c]++;
            end
         end
         m_credit = pv;
         m_ch = chip_intf_channel;
         m_dat = chip_intf_data;
      end
   end

   // Monitor: compares every presented flit and the flag outputs half a cycle after the edge.
   always @(negedge io_clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("noc_valid[%0d]", k), noc_valid[k], mq[k].size() != 0);
            if (noc_valid[k]) begin
               if (sb[k].size() == 0) begin
                  n_chk++;
                  $display("FAIL noc_data[%0d]: got %0h with no flit expected at %0t", k, noc_data[k*W +: W], $time);
               end else begin
                  chk($sformatf("noc_data[%0d]", k), noc_data[k*W +: W], sb[k][0]);
                  if (noc_ready[k]) void'(sb[k].pop_front());
               end
            end
`ifdef CHIP_INTF_RX_STATS_EN
            chk($sformatf("flit_cnt[%0d]", k), flit_cnt[k*32 +: 32], m_flits[k]);
            chk($sformatf("drop_cnt[%0d]", k), drop_cnt[k*16 +: 16], m_drops[k][15:0]);
`endif
         end
         chk("credit_back", chip_intf_credit_back, m_credit);
         chk("overflow_err", overflow_err, m_ovf);
      end
   end

   task automatic drive(input logic [1:0] ch, input logic [W-1:0] d, input logic [2:0] rdy);
      chip_intf_channel = ch;
      chip_intf_data    = d;
      noc_ready         = rdy;
      @(posedge io_clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [2:0] rdy);
      for (int i = 0; i < n; i++) drive(2'd0, $urandom, rdy);
   endtask

   initial begin
      int cr;
      logic [2:0] r;

      repeat (3) @(posedge io_clk);
      #1;
      chk("reset_valid", noc_valid, 3'b000);
      chk("reset_credit", chip_intf_credit_back, 3'b000);
      chk("reset_ovf", overflow_err, 3'b000);
      rst = 1'b0;

      // Single NoC2 flit: valid after the write edge, credit one edge later.
      drive(2'd2, 32'hDEADBEEF, 3'b111);
      drive(2'd0, 32'h0, 3'b111);
      chk("t1_valid", noc_valid, 3'b010);
      chk("t1_data", noc_data[2*W-1 -: W], 32'hDEADBEEF);
      drive(2'd0, 32'h0, 3'b111);
      chk("t1_credit", chip_intf_credit_back, 3'b010);
      idle(2, 3'b111);

      // Fill NoC1 with no consumer, then drain counting credits.
      for (int i = 0; i < DEPTH; i++) drive(2'd1, $urandom, 3'b000);
      idle(2, 3'b000);
      chk("t2_full_valid", noc_valid, 3'b001);
      cr = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(2'd0, $urandom, 3'b001);
         cr += int'(chip_intf_credit_back[0]);
      end
      chk("t2_credits", cr, DEPTH);
      chk("t2_no_err", overflow_err, 3'b000);

      // Full NoC1 with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) drive(2'd1, $urandom, 3'b000);
      idle(1, 3'b000);
      drive(2'd1, 32'hA5A50001, 3'b000);
      drive(2'd0, 32'h0, 3'b001);
      chk("t4_credit", chip_intf_credit_back, 3'b001);
      idle(1, 3'b000);
      chk("t4_no_err", overflow_err, 3'b000);
      idle(DEPTH + 2, 3'b001);

      // NoC3 overflow: the ninth flit is dropped.
      for (int i = 0; i < DEPTH; i++) drive(2'd3, 32'h3000_0000 + i, 3'b000);
      drive(2'd3, 32'h1, 3'b000);
      idle(2, 3'b000);
      chk("t3_ovf", overflow_err, 3'b100);
`ifdef CHIP_INTF_RX_STATS_EN
      chk("t3_drop_cnt", drop_cnt[47:32], 16'd1);
`endif
      idle(DEPTH + 2, 3'b100);
      chk("t3_drained", noc_valid, 3'b000);

      // Interleaved channels including an idle slot.
      drive(2'd1, 32'h11, 3'b111);
      drive(2'd2, 32'h22, 3'b111);
      drive(2'd3, 32'h33, 3'b111);
      drive(2'd0, 32'hFF, 3'b111);
      drive(2'd1, 32'h44, 3'b111);
      idle(4, 3'b111);

      // Reset with occupied buffer, pending credit and a flit in the pin register.
      for (int i = 0; i < 4; i++) drive(2'd2, $urandom, 3'b000);
      idle(1, 3'b000);
      drive(2'd2, 32'h5555AAAA, 3'b010);
      rst = 1'b1;
      #1;
      chk("t6_valid", noc_valid, 3'b000);
      chk("t6_credit", chip_intf_credit_back, 3'b000);
      chk("t6_ovf", overflow_err, 3'b000);
      @(posedge io_clk);
      #1;
      rst = 1'b0;
      drive(2'd3, 32'hCAFE0003, 3'b111);
      drive(2'd0, 32'h0, 3'b111);
      chk("t6_post_valid", noc_valid, 3'b100);
      idle(3, 3'b111);

      // Random traffic, first with mostly ready consumers, then starved to provoke drops.
      for (int i = 0; i < 1500; i++) begin
         r = {3{1'b0}};
         for (int k = 0; k < 3; k++) r[k] = ($urandom_range(0, 3) != 0);
         drive(2'($urandom_range(0, 3)), $urandom, r);
      end
      for (int i = 0; i < 400; i++) begin
         r = {3{1'b0}};
         for (int k = 0; k < 3; k++) r[k] = ($urandom_range(0, 3) == 0);
         drive(2'($urandom_range(0, 3)), $urandom, r);
      end
      idle(DEPTH + 4, 3'b111);
      for (int k = 0; k < 3; k++) chk($sformatf("end_sb_empty[%0d]", k), sb[k].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
